lcd_bus_writer: RTL and testbench
=================================

// Module: lcd_bus_writer
// PURPOSE
//  Drives the 8-bit 8080-style write bus of an ILI9341/ILI9488 LCD.
//  - Accepts command bytes, data bytes, 18-bit pixels and control words from the CPU.
//  - Pixels come from the GPU pixel result.
//  - Entries are buffered in a small FIFO, then serialized as timed WRX strobes with DCX/CSX.
//  - Sits between the CPU I/O decode and the LCD pins. It is the bus-side consumer of GPU output.
// PARAMETERS
//  WIDTH       18  CPU data width. Pixel occupies a[17:0]; WIDTH >= 18.
//  DEPTH_LOG2  2   FIFO depth = 2**DEPTH_LOG2 entries.
//  TWL         2   Cycles lcd_wr_n is held low per byte (>=1).
//  TWH         2   Cycles lcd_wr_n is held high per byte (>=1).
// PORTS
//  clk       in   1      Clock.
//  rst_n     in   1      Synchronous active-low reset.
//  sel       in   2      Entry kind: 0 = command byte, 1 = data byte, 2 = pixel, 3 = control.
//  go        in   1      Push {sel,a} into the FIFO this cycle.
//  busy      out  1      FIFO full. A go while busy is dropped.
//  y         out  WIDTH  Status, zero-extended: {ovf,full,level[DEPTH_LOG2:0],idle}.
//  a         in   WIDTH  Entry payload.
//  lcd_cs_n  out  1      CSX.
//  lcd_dc    out  1      DCX: 0 = command, 1 = data.
//  lcd_wr_n  out  1      WRX. The LCD latches on the rising edge.
//  lcd_rst_n out  1      LCD hardware reset pin.
//  lcd_d     out  8      Data bus.
// BEHAVIOUR
//  Reset values:
//   - lcd_cs_n = 1, lcd_dc = 1, lcd_wr_n = 1, lcd_rst_n = 0, lcd_d = 0.
//   - FIFO empty, ovf = 0, busy = 0, mode565 = 0, FSM in IDLE.
//   - Reset mid-strobe forces lcd_wr_n = 1 at that edge. The partial byte is discarded.
//  Push rules:
//   - go && !busy writes the entry at edge E0.
//   - go && busy drops the entry and sets the sticky ovf.
//   - A simultaneous pop and push when full is still refused: busy is evaluated pre-pop.
//  FSM states:
//   - IDLE: if FIFO non-empty at E1, pop the entry.
//     - Kind 3: apply control in the same edge, stay in IDLE. 1 cycle per control entry.
//     - Kinds 0-2: load the byte list; nbytes = 1, or 3 for a pixel (2 in 565 mode). Go to WRLO.
//   - WRLO: entered with lcd_d/lcd_dc valid and lcd_wr_n = 0. Hold TWL cycles, then go to WRHI.
//   - WRHI: lcd_wr_n = 1 for TWH cycles. Then:
//     - more bytes remain: next byte on lcd_d, back to WRLO;
//     - otherwise: go to IDLE.
//   - Back-to-back entries: IDLE pops in the cycle after WRHI ends. Byte period = TWL+TWH; entry gap = 1 cycle.
//  Latency: first lcd_wr_n fall is at E1, one edge after the accepting go edge, given an empty FIFO and FSM in IDLE.
//  lcd_d and lcd_dc change only on edges where lcd_wr_n goes low, so they are stable through each rising edge.
//  lcd_dc: kind 0 drives 0; kinds 1 and 2 drive 1.
//  Byte formats:
//   - Kinds 0/1: lcd_d = a[7:0].
//   - Pixel, 18bpp: {p[17:12],2'b00}, then {p[11:6],2'b00}, then {p[5:0],2'b00}.
//  Control word (kind 3), applied in FIFO order:
//   - a[0] = 1 drives lcd_cs_n = 0.
//   - a[1] goes to lcd_rst_n.
//   - a[2] sets mode565.
//   - a[3] = 1 clears ovf.
//  idle = FIFO empty and FSM in IDLE. level counts 0..DEPTH.
// CONFIGURATION
//  LCD_RGB565_EN defined:
//   - The mode565 bit exists.
//   - A pixel in 565 mode sends 2 bytes: {p[17:13],p[11:9]}, then {p[8:6],p[5:1]}.
//  LCD_RGB565_EN undefined:
//   - a[2] is ignored, mode565 is tied to 0, and pixels always send 3 bytes.
// STRUCTURE
//  Package lcd_pkg:
//   - Kind codes (CMD, DAT, PIX, CTL).
//   - FSM state encoding (IDLE, WRLO, WRHI).
//   - Control bit positions.
//   - Pixel-to-byte formatting function.
//  Sub-module lcd_fifo:
//   - Synchronous FIFO of {sel,a[17:0]}, DEPTH_LOG2 deep.
//   - Outputs full, empty and level.
// TESTING
//  - Reset, then ctl a=3 -> lcd_cs_n = 0 and lcd_rst_n = 1 one edge after pop; y idle bit = 1.
//  - cmd a=0x2C, TWL=TWH=2 -> lcd_dc = 0, lcd_d = 0x2C; lcd_wr_n low 2 cycles, high 2; falls at E1.
//  - Pixel 0x3F03F (18bpp) -> bytes 0xFC, 0x00, 0xFC, dc = 1; 12 cycles total, then idle.
//  - LCD_RGB565_EN, ctl a=7, pixel 0x3FFC0 -> bytes 0xFF, 0xE0 only.
//  - Push 5 data bytes with DEPTH=4 while stalled -> 5th dropped, ovf = 1, busy = 1; ctl a[3] = 1 clears ovf.
//  - Assert rst_n = 0 during WRLO of a pixel -> lcd_wr_n = 1 next edge, FIFO empty, no further strobes.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD 8080-style write bus: entry kinds, FSM
// encoding, control-word bit positions and the pixel-to-byte formatter.
package lcd_pkg;

  localparam logic [1:0] KIND_CMD = 2'd0;
  localparam logic [1:0] KIND_DAT = 2'd1;
  localparam logic [1:0] KIND_PIX = 2'd2;
  localparam logic [1:0] KIND_CTL = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WRLO = 2'd1;
  localparam logic [1:0] ST_WRHI = 2'd2;

  localparam int unsigned CTL_CS  = 0;
  localparam int unsigned CTL_RST = 1;
  localparam int unsigned CTL_565 = 2;
  localparam int unsigned CTL_OVF = 3;

  localparam int unsigned PIX_W   = 18;
  localparam int unsigned ENTRY_W = 2 + PIX_W;

  typedef struct packed {
    logic [1:0]       kind;
    logic [PIX_W-1:0] payload;
  } entry_t;

  // Byte idx of an 18-bit pixel, either 6:6:6 (3 bytes) or packed 5:6:5 (2 bytes).
  function automatic logic [7:0] pix_byte(input logic [PIX_W-1:0] p,
                                          input logic [1:0] idx,
                                          input logic m565);
    logic [7:0] b;
    b = 8'h00;
    if (m565) begin
      case (idx)
        2'd0:    b = {p[17:13], p[11:9]};
        default: b = {p[8:6], p[5:1]};
      endcase
    end else begin
      case (idx)
        2'd0:    b = {p[17:12], 2'b00};
        2'd1:    b = {p[11:6], 2'b00};
        default: b = {p[5:0], 2'b00};
      endcase
    end
    return b;
  endfunction

  function automatic logic [7:0] entry_byte(input entry_t e,
                                            input logic [1:0] idx,
                                            input logic m565);
    if (e.kind == KIND_PIX) return pix_byte(e.payload, idx, m565);
    return e.payload[7:0];
  endfunction

endpackage

// File: rtl/lcd_fifo.sv
// Synchronous FIFO of {kind, payload} entries with registered full/empty/level.
module lcd_fifo
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [ENTRY_W-1:0]   wdata,
  output logic [ENTRY_W-1:0]   head_c,
  output logic                 full,
  output logic                 empty,
  output logic [DEPTH_LOG2:0]  level
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [LW-1:0]         level_nx;
  logic                  do_push;
  logic                  do_pop;

  // Both qualifiers use pre-update flags, so a push into a full FIFO is refused even when popping.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_c  = mem[rptr];

  always_comb begin
    level_nx = level;
    if (do_push && !do_pop)      level_nx = level + LW'(1);
    else if (!do_push && do_pop) level_nx = level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + DEPTH_LOG2'(1);
      if (do_pop)  rptr <= rptr + DEPTH_LOG2'(1);
      level <= level_nx;
      full  <= (level_nx == LW'(DEPTH));
      empty <= (level_nx == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/lcd_bus_writer.sv
// Buffers CPU command/data/pixel/control entries and serializes them onto an
// 8080-style LCD write bus. Define LCD_RGB565_EN to enable 5:6:5 pixel packing.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int unsigned WIDTH      = 18,
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned TWL        = 2,
  parameter int unsigned TWH        = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       sel,
  input  logic             go,
  output logic             busy,
  output logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] a,
  output logic             lcd_cs_n,
  output logic             lcd_dc,
  output logic             lcd_wr_n,
  output logic             lcd_rst_n,
  output logic [7:0]       lcd_d
);

  localparam int unsigned TMAX = (TWL > TWH) ? TWL : TWH;
  localparam int unsigned CW   = $clog2(TMAX + 1);

  logic [ENTRY_W-1:0]  head_raw;
  entry_t              head;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] level;
  logic                push_c;
  logic                pop_c;
  logic                idle_c;

  logic [1:0]    state_q, state_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic [1:0]    idx_q, idx_nx;
  logic [1:0]    nb_q, nb_nx;
  entry_t        ent_q, ent_nx;
  logic          mode_q, mode_nx;
  logic          ovf_q, ovf_nx;
  logic [7:0]    d_nx;
  logic          dc_nx, wr_nx, cs_nx, lrst_nx;

  assign push_c = go && !full;
  assign busy   = full;
  assign head   = entry_t'(head_raw);
  assign idle_c = empty && (state_q == ST_IDLE);
  assign y      = WIDTH'({ovf_q, full, level, idle_c});

  if (WIDTH > PIX_W) begin : g_wide
    logic unused_hi;
    assign unused_hi = ^a[WIDTH-1:PIX_W];
  end

  lcd_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push_c),
    .pop    (pop_c),
    .wdata  ({sel, a[PIX_W-1:0]}),
    .head_c (head_raw),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nx;
  end

  // Next-state and next-output logic; lcd_d/lcd_dc only move together with a wr_n fall.
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    idx_nx   = idx_q;
    nb_nx    = nb_q;
    ent_nx   = ent_q;
    mode_nx  = mode_q;
    ovf_nx   = ovf_q;
    d_nx     = lcd_d;
    dc_nx    = lcd_dc;
    wr_nx    = lcd_wr_n;
    cs_nx    = lcd_cs_n;
    lrst_nx  = lcd_rst_n;
    pop_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop_c = 1'b1;
          if (head.kind == KIND_CTL) begin
            cs_nx   = ~head.payload[CTL_CS];
            lrst_nx = head.payload[CTL_RST];
`ifdef LCD_RGB565_EN
            mode_nx = head.payload[CTL_565];
`endif
            if (head.payload[CTL_OVF]) ovf_nx = 1'b0;
          end else begin
            ent_nx   = head;
            idx_nx   = 2'd0;
            nb_nx    = (head.kind == KIND_PIX) ? (mode_q ? 2'd2 : 2'd3) : 2'd1;
            d_nx     = entry_byte(head, 2'd0, mode_q);
            dc_nx    = (head.kind != KIND_CMD);
            wr_nx    = 1'b0;
            cnt_nx   = '0;
            state_nx = ST_WRLO;
          end
        end
      end
      ST_WRLO: begin
        if (cnt_q == CW'(TWL - 1)) begin
          wr_nx    = 1'b1;
          cnt_nx   = '0;
          state_nx = ST_WRHI;
        end else begin
          cnt_nx = cnt_q + CW'(1);
        end
      end
      ST_WRHI: begin
        if (cnt_q == CW'(TWH - 1)) begin
          cnt_nx = '0;
          if ((idx_q + 2'd1) < nb_q) begin
            idx_nx   = idx_q + 2'd1;
            d_nx     = entry_byte(ent_q, idx_q + 2'd1, mode_q);
            wr_nx    = 1'b0;
            state_nx = ST_WRLO;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          cnt_nx = cnt_q + CW'(1);
        end
      end
      default: begin
        wr_nx    = 1'b1;
        cnt_nx   = '0;
        state_nx = ST_IDLE;
      end
    endcase

    if (go && full) ovf_nx = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      nb_q      <= '0;
      ent_q     <= '0;
      mode_q    <= 1'b0;
      ovf_q     <= 1'b0;
      lcd_d     <= 8'h00;
      lcd_dc    <= 1'b1;
      lcd_wr_n  <= 1'b1;
      lcd_cs_n  <= 1'b1;
      lcd_rst_n <= 1'b0;
    end else begin
      cnt_q     <= cnt_nx;
      idx_q     <= idx_nx;
      nb_q      <= nb_nx;
      ent_q     <= ent_nx;
      mode_q    <= mode_nx;
      ovf_q     <= ovf_nx;
      lcd_d     <= d_nx;
      lcd_dc    <= dc_nx;
      lcd_wr_n  <= wr_nx;
      lcd_cs_n  <= cs_nx;
      lcd_rst_n <= lrst_nx;
    end
  end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Directed self-checking bench for lcd_bus_writer (TWL = TWH = 2, depth 4).
module tb_lcd_bus_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        go = 1'b0;
  logic        busy;
  logic [17:0] y;
  logic [17:0] a = 18'h0;
  logic        lcd_cs_n, lcd_dc, lcd_wr_n, lcd_rst_n;
  logic [7:0]  lcd_d;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_bus_writer #(
    .WIDTH(18), .DEPTH_LOG2(2), .TWL(2), .TWH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .go(go), .busy(busy), .y(y), .a(a),
    .lcd_cs_n(lcd_cs_n), .lcd_dc(lcd_dc), .lcd_wr_n(lcd_wr_n),
    .lcd_rst_n(lcd_rst_n), .lcd_d(lcd_d)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] k, input logic [17:0] v);
    sel = k;
    a   = v;
    go  = 1'b1;
    tick();
    go  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (lcd_wr_n !== 1'b1) begin n_fail++; $display("FAIL reset_wr_n: got %b expected 1", lcd_wr_n); end
    n_checks++; if (lcd_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b expected 1", lcd_cs_n); end
    n_checks++; if (lcd_dc !== 1'b1) begin n_fail++; $display("FAIL reset_dc: got %b expected 1", lcd_dc); end
    n_checks++; if (lcd_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_lcd_rst_n: got %b expected 0", lcd_rst_n); end
    n_checks++; if (lcd_d !== 8'h00) begin n_fail++; $display("FAIL reset_d: got %h expected 00", lcd_d); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (y !== 18'h1) begin n_fail++; $display("FAIL reset_y: got %h expected 00001", y); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_control();
    push(2'd3, 18'h3);
    n_checks++; if (y !== 18'h2) begin n_fail++; $display("FAIL ctl_y_queued: got %h expected 00002", y); end
    tick();
    n_checks++; if (lcd_cs_n !== 1'b0) begin n_fail++; $display("FAIL ctl_cs_n: got %b expected 0", lcd_cs_n); end
    n_checks++; if (lcd_rst_n !== 1'b1) begin n_fail++; $display("FAIL ctl_lcd_rst_n: got %b expected 1", lcd_rst_n); end
    n_checks++; if (y !== 18'h1) begin n_fail++; $display("FAIL ctl_y_idle: got %h expected 00001", y); end
  endtask

  task automatic test_cmd();
    logic exp_wr [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    push(2'd0, 18'h2C);
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++; if (lcd_wr_n !== exp_wr[k]) begin n_fail++; $display("FAIL cmd_wr_n[%0d]: got %b expected %b", k, lcd_wr_n, exp_wr[k]); end
      n_checks++; if (lcd_d !== 8'h2C) begin n_fail++; $display("FAIL cmd_d[%0d]: got %h expected 2c", k, lcd_d); end
      n_checks++; if (lcd_dc !== 1'b0) begin n_fail++; $display("FAIL cmd_dc[%0d]: got %b expected 0", k, lcd_dc); end
      if (k == 3) begin
        n_checks++; if (y[0] !== 1'b0) begin n_fail++; $display("FAIL cmd_busy_idle: got %b expected 0", y[0]); end
      end
    end
    n_checks++; if (y !== 18'h1) begin n_fail++; $display("FAIL cmd_y_done: got %h expected 00001", y); end
  endtask

  task automatic test_pixel_18();
    logic [7:0] exp_b [3] = '{8'hFC, 8'h00, 8'hFC};
    logic       exp_w;
    push(2'd2, 18'h3F03F);
    for (int k = 0; k < 12; k++) begin
      tick();
      exp_w = ((k % 4) >= 2);
      n_checks++; if (lcd_wr_n !== exp_w) begin n_fail++; $display("FAIL pix_wr_n[%0d]: got %b expected %b", k, lcd_wr_n, exp_w); end
      n_checks++; if (lcd_d !== exp_b[k/4]) begin n_fail++; $display("FAIL pix_d[%0d]: got %h expected %h", k, lcd_d, exp_b[k/4]); end
      n_checks++; if (lcd_dc !== 1'b1) begin n_fail++; $display("FAIL pix_dc[%0d]: got %b expected 1", k, lcd_dc); end
    end
    n_checks++; if (y[0] !== 1'b0) begin n_fail++; $display("FAIL pix_not_idle_e12: got %b expected 0", y[0]); end
    tick();
    n_checks++; if (y !== 18'h1) begin n_fail++; $display("FAIL pix_idle: got %h expected 00001", y); end
    n_checks++; if (lcd_wr_n !== 1'b1) begin n_fail++; $display("FAIL pix_wr_end: got %b expected 1", lcd_wr_n); end
  endtask

  task automatic test_rgb565();
`ifdef LCD_RGB565_EN
    int         nb = 2;
    logic [7:0] exp_b [3] = '{8'hFF, 8'hE0, 8'h00};
`else
    int         nb = 3;
    logic [7:0] exp_b [3] = '{8'hFC, 8'hFC, 8'h00};
`endif
    logic exp_w;
    push(2'd3, 18'h7);
    tick();
    push(2'd2, 18'h3FFC0);
    for (int k = 0; k < nb * 4; k++) begin
      tick();
      exp_w = ((k % 4) >= 2);
      n_checks++; if (lcd_wr_n !== exp_w) begin n_fail++; $display("FAIL p565_wr_n[%0d]: got %b expected %b", k, lcd_wr_n, exp_w); end
      n_checks++; if (lcd_d !== exp_b[k/4]) begin n_fail++; $display("FAIL p565_d[%0d]: got %h expected %h", k, lcd_d, exp_b[k/4]); end
    end
    tick();
    n_checks++; if (y !== 18'h1) begin n_fail++; $display("FAIL p565_idle: got %h expected 00001", y); end
    push(2'd3, 18'h3);
    tick();
  endtask

  task automatic test_overflow();
    logic [7:0] cap [8];
    int         ncap;
    logic       pw;
    logic       done;
    logic [7:0] exp_b [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    push(2'd2, 18'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      sel = 2'd1;
      a   = 18'(8'h11 * (i + 1));
      go  = 1'b1;
      tick();
      if (i == 3) begin
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovf_busy_full: got %b expected 1", busy); end
      end
    end
    go = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovf_busy: got %b expected 1", busy); end
    n_checks++; if (y !== 18'h38) begin n_fail++; $display("FAIL ovf_y_full: got %h expected 00038", y); end
    ncap = 0;
    done = 1'b0;
    pw   = lcd_wr_n;
    for (int t = 0; t < 200 && !done; t++) begin
      tick();
      if (!pw && lcd_wr_n) begin
        if (ncap < 8) cap[ncap] = lcd_d;
        ncap++;
      end
      pw = lcd_wr_n;
      if (y[0]) done = 1'b1;
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_timeout: got %b expected 1", done); end
    n_checks++; if (ncap !== 6) begin n_fail++; $display("FAIL ovf_byte_count: got %0d expected 6", ncap); end
    for (int j = 0; j < 6; j++) begin
      if (j < ncap) begin
        n_checks++; if (cap[j] !== exp_b[j]) begin n_fail++; $display("FAIL ovf_byte[%0d]: got %h expected %h", j, cap[j], exp_b[j]); end
      end
    end
    n_checks++; if (y !== 18'h21) begin n_fail++; $display("FAIL ovf_sticky: got %h expected 00021", y); end
    push(2'd3, 18'hB);
    tick();
    n_checks++; if (y !== 18'h1) begin n_fail++; $display("FAIL ovf_clear: got %h expected 00001", y); end
    n_checks++; if (lcd_cs_n !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_cs: got %b expected 0", lcd_cs_n); end
  endtask

  task automatic test_back_to_back();
    logic       exp_w [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] exp_d [9] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
    push(2'd0, 18'hA5);
    sel = 2'd1;
    a   = 18'h5A;
    go  = 1'b1;
    tick();
    go  = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) tick();
      n_checks++; if (lcd_wr_n !== exp_w[k]) begin n_fail++; $display("FAIL b2b_wr_n[%0d]: got %b expected %b", k, lcd_wr_n, exp_w[k]); end
      n_checks++; if (lcd_d !== exp_d[k]) begin n_fail++; $display("FAIL b2b_d[%0d]: got %h expected %h", k, lcd_d, exp_d[k]); end
      n_checks++; if (lcd_dc !== (k >= 5)) begin n_fail++; $display("FAIL b2b_dc[%0d]: got %b expected %b", k, lcd_dc, (k >= 5)); end
    end
    tick();
    n_checks++; if (y !== 18'h1) begin n_fail++; $display("FAIL b2b_idle: got %h expected 00001", y); end
  endtask

  task automatic test_reset_mid();
    int lows;
    push(2'd2, 18'h3F03F);
    sel = 2'd1;
    a   = 18'h77;
    go  = 1'b1;
    tick();
    go  = 1'b0;
    n_checks++; if (lcd_wr_n !== 1'b0) begin n_fail++; $display("FAIL rmid_in_wrlo: got %b expected 0", lcd_wr_n); end
    rst_n = 1'b0;
    tick();
    n_checks++; if (lcd_wr_n !== 1'b1) begin n_fail++; $display("FAIL rmid_wr_n: got %b expected 1", lcd_wr_n); end
    n_checks++; if (y !== 18'h1) begin n_fail++; $display("FAIL rmid_y: got %h expected 00001", y); end
    n_checks++; if (lcd_rst_n !== 1'b0) begin n_fail++; $display("FAIL rmid_lcd_rst_n: got %b expected 0", lcd_rst_n); end
    n_checks++; if (lcd_cs_n !== 1'b1) begin n_fail++; $display("FAIL rmid_cs_n: got %b expected 1", lcd_cs_n); end
    rst_n = 1'b1;
    lows  = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (lcd_wr_n !== 1'b1) lows++;
    end
    n_checks++; if (lows !== 0) begin n_fail++; $display("FAIL rmid_no_strobes: got %0d low cycles expected 0", lows); end
    n_checks++; if (y !== 18'h1) begin n_fail++; $display("FAIL rmid_final_y: got %h expected 00001", y); end
  endtask

  initial begin
    test_reset();
    test_control();
    test_cmd();
    test_pixel_18();
    test_rgb565();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
